// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, status bit layout, default addresses.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int BUSY   = 0;
  localparam int FULL   = 1;
  localparam int OVF    = 2;
  localparam int PAR    = 3;
  localparam int CNT_LO = 4;
  localparam int CNT_W  = 4;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hF000_0030;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0130;

endpackage

// File: rtl/uart_tx_controller_fifo.sv
// byte_fifo: circular buffer with one extra pointer bit to tell full from empty.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;
  assign dout  = mem[rd_q[AW-1:0]];

  // A push into a full buffer is only accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_controller.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO and status register.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] DATA_ADDR  = DBITS'(DEF_DATA_ADDR),
  parameter logic [DBITS-1:0] CTRL_ADDR  = DBITS'(DEF_CTRL_ADDR),
  parameter int               CLKDIV     = 5208,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [DBITS-1:0] dbus,
  input  logic [DBITS-1:0] address,
  input  logic             wrtEn,
  output logic             tx
);

  localparam int                AW        = $clog2(FIFO_DEPTH);
  localparam int                BAUD_W    = $clog2(CLKDIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKDIV - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        last_q, last_d;
`ifdef UART_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              wr_data, wr_ctrl, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [AW:0]       fifo_count;
  logic [DBITS-1:0]  status, rd_data;

  assign wr_data = wrtEn && (address == DATA_ADDR);
  assign wr_ctrl = wrtEn && (address == CTRL_ADDR);
  assign tx      = tx_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (dbus[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status            = '0;
    status[BUSY]      = (state_q != ST_IDLE) || !fifo_empty;
    status[FULL]      = fifo_full;
    status[OVF]       = ovf_q;
`ifdef UART_PARITY_EN
    status[PAR]       = 1'b1;
`endif
    status[CNT_LO +: CNT_W] = CNT_W'(fifo_count);
    rd_data = (address == DATA_ADDR) ? {{(DBITS-8){1'b0}}, last_q} : status;
  end

  assign dbus = (!wrtEn && (address == DATA_ADDR || address == CTRL_ADDR)) ? rd_data
                                                                           : {DBITS{1'bz}};

  // A dropped byte still updates the last-byte register; a same-cycle pop makes room instead.
  always_comb begin
    last_d = wr_data ? dbus[7:0] : last_q;
    ovf_d  = ovf_q;
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
    else if (wr_ctrl && !dbus[OVF])        ovf_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = BAUD_LOAD;
          state_d  = ST_START;
`ifdef UART_PARITY_EN
          par_d    = ^fifo_dout;
`endif
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          idx_d   = '0;
          baud_d  = BAUD_LOAD;
        end else baud_d = baud_q - BAUD_W'(1);
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          shift_d = shift_q >> 1;
          baud_d  = BAUD_LOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else idx_d = idx_q + 3'd1;
        end else baud_d = baud_q - BAUD_W'(1);
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (baud_q == '0) begin
          state_d = ST_STOP;
          baud_d  = BAUD_LOAD;
        end else baud_d = baud_q - BAUD_W'(1);
      end
`endif
      ST_STOP: begin
        if (baud_q == '0) state_d = ST_IDLE;
        else              baud_d  = baud_q - BAUD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line follows the current state one cycle later, so every bit is a clean flop output.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller (CLKDIV=4, FIFO_DEPTH=4).
module tb_uart_tx_controller;

  localparam logic [31:0] DADDR = 32'hF000_0030;
  localparam logic [31:0] CADDR = 32'hF000_0130;
`ifdef UART_PARITY_EN
  localparam int          P     = 1;
  localparam logic [31:0] PBIT  = 32'h8;
`else
  localparam int          P     = 0;
  localparam logic [31:0] PBIT  = 32'h0;
`endif
  localparam int NB = 10 + P;

  logic        clk, reset, wrtEn, drv_en;
  logic [31:0] address, drv_val;
  tri1  [31:0] dbus;
  wire         tx;
  int          total, bad;

  assign dbus = drv_en ? drv_val : 32'bz;

  uart_tx_controller #(
    .DBITS(32), .DATA_ADDR(DADDR), .CTRL_ADDR(CADDR), .CLKDIV(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .dbus(dbus), .address(address), .wrtEn(wrtEn), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    address = a; wrtEn = 1'b0; drv_en = 1'b0;
    #1 v = dbus;
    address = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address = a; wrtEn = 1'b1; drv_val = d; drv_en = 1'b1;
    @(negedge clk);
    wrtEn = 1'b0; drv_en = 1'b0; address = 32'h0;
  endtask

  // start_off < 0: wait for the start bit; otherwise we are already start_off cycles into it.
  task automatic rx_byte(input int start_off, output logic [7:0] b, output logic ok);
    int cur, waited, t;
    ok = 1'b1; b = 8'h00; cur = start_off;
    if (start_off < 0) begin
      waited = 0;
      while (tx !== 1'b0 && waited < 400) begin @(negedge clk); waited++; end
      if (tx !== 1'b0) begin ok = 1'b0; return; end
      cur = 0;
    end
    if (cur <= 2) begin
      repeat (2 - cur) @(negedge clk);
      cur = 2;
      if (tx !== 1'b0) ok = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      t = 4 * (k + 1) + 2;
      repeat (t - cur) @(negedge clk);
      cur = t; b[k] = tx;
    end
    if (P == 1) begin
      repeat (38 - cur) @(negedge clk);
      cur = 38;
      if (tx !== ^b) ok = 1'b0;
    end
    t = 4 * (9 + P) + 2;
    repeat (t - cur) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    bus_read(CADDR, v);
    total++; if (v !== PBIT) begin bad++; $display("FAIL reset_ctrl: got %h want %h", v, PBIT); end
    bus_read(DADDR, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", v); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame_55();
    logic [31:0] v;
    logic [7:0]  d;
    logic        exp_tx, exp_busy;
    int          b;
    d = 8'h55;
    bus_write(DADDR, {24'h0, d});
    bus_read(CADDR, v);
    total++; if (v !== (32'h11 | PBIT)) begin bad++; $display("FAIL f55_ctrl_queued: got %h want %h", v, 32'h11 | PBIT); end
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4 * NB; j++) begin
      b = j / 4;
      if (b == 0)               exp_tx = 1'b0;
      else if (b <= 8)          exp_tx = d[b-1];
      else if (P == 1 && b == 9) exp_tx = ^d;
      else                      exp_tx = 1'b1;
      total++; if (tx !== exp_tx) begin bad++; $display("FAIL f55_tx[%0d]: got %b want %b", j, tx, exp_tx); end
      exp_busy = (j < 4 * NB - 1);
      bus_read(CADDR, v);
      total++; if (v[0] !== exp_busy) begin bad++; $display("FAIL f55_busy[%0d]: got %b want %b", j, v[0], exp_busy); end
      @(negedge clk);
    end
    bus_read(CADDR, v);
    total++; if (v !== PBIT) begin bad++; $display("FAIL f55_ctrl_done: got %h want %h", v, PBIT); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int          hi_errs;
    bus_write(DADDR, 32'hA5);
    repeat (2 + 17) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rst_mid_pre: got %b want 0", tx); end
    #2 reset = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_read(CADDR, v);
    total++; if (v !== PBIT) begin bad++; $display("FAIL rst_mid_ctrl: got %h want %h", v, PBIT); end
    bus_read(DADDR, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", v); end
    hi_errs = 0;
    repeat (60) begin @(negedge clk); if (tx !== 1'b1) hi_errs++; end
    total++; if (hi_errs !== 0) begin bad++; $display("FAIL rst_mid_quiet: low cycles %0d want 0", hi_errs); end
  endtask

  task automatic test_readback_z();
    logic [31:0] v;
    logic [7:0]  b;
    logic        ok;
    bus_write(DADDR, 32'h3C);
    bus_read(DADDR, v);
    total++; if (v !== 32'h3C) begin bad++; $display("FAIL rb_data: got %h want 0000003c", v); end
    bus_read(32'h0, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL z_addr0: got %h want ffffffff", v); end
    bus_read(32'hF000_0034, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL z_addr34: got %h want ffffffff", v); end
    address = CADDR; wrtEn = 1'b1; drv_en = 1'b0;
    #1 v = dbus;
    wrtEn = 1'b0; address = 32'h0;
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL z_wr_ctrl: got %h want ffffffff", v); end
    address = DADDR; wrtEn = 1'b1; drv_en = 1'b0;
    #1 v = dbus;
    wrtEn = 1'b0; address = 32'h0;
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL z_wr_data: got %h want ffffffff", v); end
    rx_byte(-1, b, ok);
    total++; if (ok !== 1'b1 || b !== 8'h3C) begin bad++; $display("FAIL rb_frame: got %h ok=%b want 3c", b, ok); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0]  b;
    logic        ok;
    for (int i = 1; i <= 6; i++) begin
      address = DADDR; wrtEn = 1'b1; drv_en = 1'b1; drv_val = i;
      @(negedge clk);
    end
    wrtEn = 1'b0; drv_en = 1'b0; address = 32'h0;
    bus_read(CADDR, v);
    total++; if (v !== (32'h47 | PBIT)) begin bad++; $display("FAIL ovf_ctrl: got %h want %h", v, 32'h47 | PBIT); end
    bus_read(DADDR, v);
    total++; if (v !== 32'h06) begin bad++; $display("FAIL ovf_last: got %h want 00000006", v); end
    for (int i = 1; i <= 5; i++) begin
      rx_byte((i == 1) ? 3 : -1, b, ok);
      total++; if (ok !== 1'b1 || b !== 8'(i)) begin bad++; $display("FAIL ovf_frame%0d: got %h ok=%b want %h", i, b, ok, 8'(i)); end
    end
    repeat (4) @(negedge clk);
    bus_read(CADDR, v);
    total++; if (v !== (32'h04 | PBIT)) begin bad++; $display("FAIL ovf_sticky: got %h want %h", v, 32'h04 | PBIT); end
    bus_write(CADDR, 32'h0);
    bus_read(CADDR, v);
    total++; if (v !== PBIT) begin bad++; $display("FAIL ovf_clear: got %h want %h", v, PBIT); end
    repeat (30) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL ovf_no_extra: got %b want 1", tx); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] v;
    logic [7:0]  b;
    logic        ok;
    logic [7:0]  bytes [6];
    bytes[0] = 8'hC1; bytes[1] = 8'h82; bytes[2] = 8'h43;
    bytes[3] = 8'h24; bytes[4] = 8'h18; bytes[5] = 8'hE7;
    for (int i = 0; i < 5; i++) begin
      address = DADDR; wrtEn = 1'b1; drv_en = 1'b1; drv_val = {24'h0, bytes[i]};
      @(negedge clk);
    end
    wrtEn = 1'b0; drv_en = 1'b0; address = 32'h0;
    bus_read(CADDR, v);
    total++; if (v !== (32'h43 | PBIT)) begin bad++; $display("FAIL ppf_fill: got %h want %h", v, 32'h43 | PBIT); end
    rx_byte(2, b, ok);
    total++; if (ok !== 1'b1 || b !== bytes[0]) begin bad++; $display("FAIL ppf_frame0: got %h ok=%b want %h", b, ok, bytes[0]); end
    @(negedge clk);
    bus_read(CADDR, v);
    total++; if (v !== (32'h43 | PBIT)) begin bad++; $display("FAIL ppf_idle_full: got %h want %h", v, 32'h43 | PBIT); end
    bus_write(DADDR, {24'h0, bytes[5]});
    bus_read(CADDR, v);
    total++; if (v !== (32'h43 | PBIT)) begin bad++; $display("FAIL ppf_after: got %h want %h", v, 32'h43 | PBIT); end
    for (int i = 1; i < 6; i++) begin
      rx_byte(-1, b, ok);
      total++; if (ok !== 1'b1 || b !== bytes[i]) begin bad++; $display("FAIL ppf_frame%0d: got %h ok=%b want %h", i, b, ok, bytes[i]); end
    end
    repeat (6) @(negedge clk);
    bus_read(CADDR, v);
    total++; if (v !== PBIT) begin bad++; $display("FAIL ppf_done: got %h want %h", v, PBIT); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    bus_write(DADDR, 32'h07);
    repeat (2 + 34) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL par_bit7: got %b want 0", tx); end
    repeat (4) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL par_bit: got %b want 1", tx); end
    repeat (4) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL par_stop: got %b want 1", tx); end
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    clk = 1'b0; reset = 1'b0; wrtEn = 1'b0; drv_en = 1'b0;
    address = 32'h0; drv_val = 32'h0;
    total = 0; bad = 0;
    test_reset();
    test_frame_55();
    test_reset_mid_frame();
    test_readback_z();
    test_overflow();
    test_push_pop_full();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
